// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and width helper for the SAR ADC controller
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        STROBE,
        DECIDE,
        HOLD
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sar_reg.sv
// rtl/sar_reg.sv - successive-approximation register: trial-bit set, keep/clear, bit index
module sar_reg
    import sar_pkg::*;
#(
    parameter int NBITS = 8,
    localparam int IW   = clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             init,
    input  logic             decide,
    input  logic             comp_out,
    output logic [NBITS-1:0] code,
    output logic [NBITS-1:0] decided,
    output logic             last
);

    logic [IW-1:0]    idx;
    logic [NBITS-1:0] bit_mask;

    assign bit_mask = NBITS'(1) << idx;
    assign decided  = comp_out ? code : (code & ~bit_mask);
    assign last     = (idx == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            code <= '0;
            idx  <= '0;
        end else if (init) begin
            code <= {1'b1, {(NBITS-1){1'b0}}};
            idx  <= IW'(NBITS - 1);
        end else if (decide) begin
            // the final decision stays in code so HOLD can present it unchanged
            if (last) begin
                code <= decided;
            end else begin
                code <= decided | (bit_mask >> 1);
                idx  <= idx - IW'(1);
            end
        end
    end

endmodule

// File: rtl/sar_ctrl.sv
// rtl/sar_ctrl.sv - SAR ADC conversion sequencer with a one-entry result register
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int SAMP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             samp,
    output logic             comp_en,
    input  logic             comp_out,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    state_t           state;
    state_t           state_next;
    logic [7:0]       samp_cnt;
    logic             samp_done;
    logic             out_free;
    logic             load;
    logic             last;
    logic [NBITS-1:0] code;
    logic [NBITS-1:0] decided;

    assign samp_done = (samp_cnt == 8'(SAMP_CYC - 1));
    assign out_free  = !dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            IDLE:   if (start) state_next = SAMPLE;
            SAMPLE: if (samp_done) state_next = STROBE;
            STROBE: state_next = DECIDE;
            DECIDE: begin
                if (!last) begin
                    state_next = STROBE;
                end else if (out_free) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_free) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state != SAMPLE) samp_cnt <= '0;
        else                        samp_cnt <= samp_cnt + 8'd1;
    end

    sar_reg #(.NBITS(NBITS)) u_sar_reg (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == IDLE && start),
        .init     (state == SAMPLE && samp_done),
        .decide   (state == DECIDE),
        .comp_out (comp_out),
        .code     (code),
        .decided  (decided),
        .last     (last)
    );

    // in HOLD the comparator is stale, so the result comes from the frozen register
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (dout_valid && dout_ready) dout_valid <= 1'b0;
            if (load) begin
                dout       <= (state == HOLD) ? code : decided;
                dout_valid <= 1'b1;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign samp     = (state == SAMPLE);
    assign comp_en  = (state == STROBE);
    assign dac_code = code;

endmodule

// File: tb/tb_sar_ctrl.sv
// tb/tb_sar_ctrl.sv - self-checking bench for sar_ctrl against an ideal comparator model
module tb_sar_ctrl;

    localparam int NBITS    = 8;
    localparam int SAMP_CYC = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             comp_out = 1'b0;
    logic             dout_ready = 1'b0;
    logic             busy, samp, comp_en, dout_valid;
    logic [NBITS-1:0] dac_code, dout;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  target = '0;
    int          cmp_mode = 0;
    logic [7:0]  q[$];

    always #5 clk = ~clk;

    sar_ctrl #(.NBITS(NBITS), .SAMP_CYC(SAMP_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .samp       (samp),
        .comp_en    (comp_en),
        .comp_out   (comp_out),
        .dac_code   (dac_code),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    // ideal comparator: decision valid the cycle after the strobe, noise otherwise
    always @(posedge clk) begin
        case (cmp_mode)
            1:       comp_out <= 1'b0;
            2:       comp_out <= 1'b1;
            default: comp_out <= comp_en ? (target >= dac_code) : 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic convert(input logic [7:0] tgt, input int mode, input bit inject,
                           input logic [7:0] exp);
        int         samp_first, samp_n, en_n, rises, vcyc, samp_dac_bad;
        logic [7:0] msb, rdout;
        logic       prev_v;
        samp_first = -1; samp_n = 0; en_n = 0; rises = 0; vcyc = -1; samp_dac_bad = 0;
        msb = '0; rdout = '0; prev_v = 1'b0;
        target = tgt; cmp_mode = mode; dout_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (samp) begin
                if (samp_first < 0) samp_first = c;
                samp_n++;
                if (dac_code != 0) samp_dac_bad++;
            end
            if (comp_en) begin
                if (en_n == 0) msb = dac_code;
                en_n++;
            end
            if (dout_valid && !prev_v) begin
                rises++;
                if (vcyc < 0) begin vcyc = c; rdout = dout; end
            end
            prev_v = dout_valid;
            if (inject && (c == 1 || c == 9)) start = 1'b1;
        end
        check("samp_first", samp_first, 1);
        check("samp_len", samp_n, SAMP_CYC);
        check("samp_dac", samp_dac_bad, 0);
        check("strobes", en_n, NBITS);
        check("msb_trial", msb, 8'h80);
        check("valid_cycle", vcyc, SAMP_CYC + 2 * NBITS + 1);
        check("dout", rdout, exp);
        check("results", rises, 1);
        check("idle_after", busy, 0);
    endtask

    task automatic step();
        @(negedge clk);
        start = 1'b0;
        dout_ready = 1'($urandom_range(0, 1));
        if (dout_valid && dout_ready) begin
            if (q.size() == 0) check("rand_spurious", 1, 0);
            else check("rand_dout", dout, q.pop_front());
        end
    endtask

    initial begin
        logic [7:0] ta, tb, tc, r;
        int         n, bad;

        repeat (2) @(negedge clk);
        check("reset_outs", {busy, samp, comp_en, dout_valid, dac_code, dout}, 0);
        rst = 1'b0;

        convert(8'hA5, 0, 0, 8'hA5);
        r = 8'($urandom);
        convert(r, 0, 0, r);
        convert(8'h5A, 1, 0, 8'h00);
        convert(8'h5A, 2, 0, 8'hFF);
        convert(8'h77, 0, 1, 8'h77);

        // abort in the DECIDE of bit 3
        target = 8'h99; cmp_mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_phase", comp_en, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", {busy, samp, comp_en, dout_valid, dac_code, dout}, 0);
        rst = 1'b0;
        convert(8'h3C, 0, 0, 8'h3C);

        // back-pressure across two conversions
        ta = 8'($urandom); tb = ~ta;
        dout_ready = 1'b0; target = ta;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!dout_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_first_timeout", n < 50, 1);
        check("bp_first", dout, ta);
        target = tb; start = 1'b1;
        @(negedge clk); start = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dout !== ta || !dout_valid) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_hold_busy", busy, 1);
        check("bp_hold_dac", dac_code, tb);
        dout_ready = 1'b1;
        @(negedge clk);
        check("bp_second", {dout_valid, busy, dout}, {1'b1, 1'b0, tb});
        dout_ready = 1'b0;

        // accept pending result and start together
        tc = 8'($urandom); target = tc;
        @(negedge clk); dout_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("acc_start", {dout_valid, samp}, 2'b01);
        n = 0;
        while (!dout_valid && n < 40) begin @(negedge clk); n++; end
        check("acc_latency", n, 18);
        check("acc_dout", dout, tc);
        repeat (2) @(negedge clk);

        // randomized traffic with random back-pressure
        cmp_mode = 0;
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) step();
            n = 0;
            while (busy && n < 100) begin step(); n++; end
            if (n >= 100) check("rand_timeout", 1, 0);
            target = 8'($urandom);
            q.push_back(target);
            start = 1'b1;
            step();
        end
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            dout_ready = 1'b1;
            if (dout_valid) check("rand_dout", dout, q.pop_front());
            n++;
        end
        check("rand_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, meaning ADC resolution in bits (legal range 2..16).
REQ-002 The block SHALL have parameter SAMP_CYC, default 2, meaning track-phase length in clk cycles (legal range 1..255).
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start SHALL be input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 Port busy SHALL be output, 1 bit: high whenever the state is not IDLE.
REQ-007 Port samp SHALL be output, 1 bit: drives the sampling switch control; high means track.
REQ-008 Port comp_en SHALL be output, 1 bit: comparator strobe.
REQ-009 Port comp_out SHALL be input, 1 bit: comparator decision, valid in the cycle after comp_en; 1 means vin >= DAC level.
REQ-010 Port dac_code SHALL be output, NBITS bits: capacitive DAC trial code.
REQ-011 Port dout SHALL be output, NBITS bits: converted result.
REQ-012 Port dout_valid SHALL be output, 1 bit: dout holds an unconsumed result.
REQ-013 Port dout_ready SHALL be input, 1 bit: the consumer accepts dout when dout_valid and dout_ready are both high on a rising edge.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, SAMPLE, STROBE, DECIDE, HOLD.
REQ-015 In IDLE with start=1, the next state SHALL be SAMPLE; in IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-016 SAMPLE SHALL last exactly SAMP_CYC cycles, with samp=1 and dac_code=0; all other states SHALL drive samp=0.
REQ-017 The bit index SHALL start at NBITS-1 on leaving SAMPLE and alternate STROBE then DECIDE for each bit, decrementing after each DECIDE.
REQ-018 On entry to STROBE for bit i, dac_code SHALL equal the bits already decided with bit i set to 1 and all lower bits 0.
REQ-019 comp_en SHALL be 1 only in STROBE cycles.
REQ-020 In DECIDE for bit i, the block SHALL keep bit i when comp_out=1 and clear it when comp_out=0; comp_out SHALL be ignored in all other states.
REQ-021 After the DECIDE for bit 0, the final code SHALL load dout and set dout_valid when the output register is free, and the FSM SHALL return to IDLE.
REQ-022 The output register is free when dout_valid=0, or when dout_valid=1 and dout_ready=1 in the same cycle.
REQ-023 When the output register is not free after bit 0, the FSM SHALL enter HOLD with dac_code frozen, and load the result and go to IDLE on the first cycle the register is free.
REQ-024 Latency: if start is sampled at edge t, samp SHALL be high in cycles t+1..t+SAMP_CYC and dout_valid SHALL rise at t+SAMP_CYC+2*NBITS+1, absent back-pressure.
REQ-025 dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-026 dout_valid SHALL clear after acceptance unless a new result loads in the same cycle.
REQ-027 start SHALL be ignored in every state except IDLE; no request is queued.
REQ-028 In IDLE, dout_ready with a pending result and a new start in the same cycle SHALL both take effect.

Reset
REQ-029 When rst=1 on a rising edge, the block SHALL enter IDLE and clear samp, comp_en, busy, dout_valid, dout, dac_code and the bit index to 0, aborting any conversion in progress.
REQ-030 Reset SHALL take priority over start and dout_ready, and no partial result SHALL ever appear on dout.

Structure
REQ-031 The state enum and a bit-index width helper, clog2(NBITS), SHALL live in shared package sar_pkg.
REQ-032 The successive-approximation register (trial-bit set, keep/clear, index counter) SHALL be sub-module sar_reg; the FSM, output register and handshake SHALL stay in sar_ctrl.

Verification (NBITS=8, SAMP_CYC=2, comparator model compares a target code against dac_code)
REQ-033 Target 0xA5, start pulse at edge 0, dout_ready=1 -> samp high in cycles 1-2, eight comp_en pulses, dout=0xA5 with dout_valid rising at cycle 19.
REQ-034 comp_out tied 0 -> dout=0x00; comp_out tied 1 -> dout=0xFF; the MSB trial code is 0x80 in both runs.
REQ-035 Hold dout_ready=0 during two back-to-back conversions -> second conversion waits in HOLD with busy=1, first dout stays stable; dout_ready=1 -> second result loads in the same cycle.
REQ-036 Pulse start in SAMPLE and in the STROBE state of bit 4 -> pulses ignored, exactly one result produced.
REQ-037 Assert rst in the DECIDE state of bit 3 -> next cycle all outputs are 0 and the state is IDLE; a following start with target 0x3C yields dout=0x3C.
REQ-038 With a pending result, assert dout_ready and start together in IDLE -> dout_valid clears next cycle, samp rises next cycle, and the new result arrives 18 cycles after that.
